// File: rtl/dl_sdram_sequencer.sv
// ROM download sequencer: queues data_io byte strobes and writes them into the
// SDRAM CPU (port1) and graphics (port2) ports over toggle req/ack handshakes.
module dl_sdram_sequencer #(
  parameter logic [24:0] GFX_BASE    = 25'h10000,
  parameter logic [24:0] DL_LIMIT    = 25'h28200,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        busy,
  output logic        overflow,
  output logic        rom_loaded,
  output logic        core_reset
);

  // state   | meaning
  // S_IDLE  | nothing in flight, waiting for a queued byte
  // S_ISSUE | drive port fields from the entry register and toggle req
  // S_WAIT  | wait until every toggled port has ack == req
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  state_t             state;
  logic [32:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic               fifo_empty, fifo_full;
  logic               push, pop, push_ok;
  logic               ioctl_wr_d, ioctl_downl_d;
  logic [24:0]        entry_addr;
  logic [7:0]         entry_data;
  logic               entry_gfx;
  logic [23:0]        gfx_off;
  logic               p2_pend;
  logic               acks_done;
  logic               dl_end_pend, end_evt, rom_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign push      = ioctl_wr & ~ioctl_wr_d & ioctl_downl & (ioctl_addr < DL_LIMIT);
  assign acks_done = (port1_ack == port1_req) && (!p2_pend || (port2_ack == port2_req));
  assign pop       = !fifo_empty && ((state == S_IDLE) || ((state == S_WAIT) && acks_done));
  assign push_ok   = push && (!fifo_full || pop);
  assign busy      = !fifo_empty || (state != S_IDLE);

  // Addresses below DL_LIMIT fit in 24 bits, so the graphics offset does too.
  assign entry_gfx = (entry_addr >= GFX_BASE);
  assign gfx_off   = entry_addr[23:0] - GFX_BASE[23:0];

  // Download end is only acted on once everything queued has drained.
  always_comb begin
    end_evt  = (dl_end_pend | (ioctl_downl_d & ~ioctl_downl)) & ~ioctl_downl & ~busy;
    rom_nxt  = rom_loaded | end_evt;
    hold_nxt = hold_cnt;
    if (end_evt)
      hold_nxt = CNT_W'(HOLD_CYCLES);
    else if (hold_cnt != '0)
      hold_nxt = hold_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {ioctl_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      ioctl_wr_d    <= 1'b0;
      ioctl_downl_d <= 1'b0;
      entry_addr    <= '0;
      entry_data    <= '0;
      p2_pend       <= 1'b0;
      port1_req     <= 1'b0;
      port1_a       <= '0;
      port1_ds      <= '0;
      port1_d       <= '0;
      port1_we      <= 1'b0;
      port2_req     <= 1'b0;
      port2_a       <= '0;
      port2_ds      <= '0;
      port2_d       <= '0;
      port2_we      <= 1'b0;
      overflow      <= 1'b0;
      rom_loaded    <= 1'b0;
      core_reset    <= 1'b1;
      hold_cnt      <= '0;
      dl_end_pend   <= 1'b0;
    end else begin
      ioctl_wr_d    <= ioctl_wr;
      ioctl_downl_d <= ioctl_downl;

      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (push && !push_ok) overflow <= 1'b1;
      if (pop) {entry_addr, entry_data} <= fifo_mem[rd_ptr[PTR_W-1:0]];

      port1_we <= ioctl_downl | busy;
      port2_we <= ioctl_downl | busy;

      case (state)
        S_IDLE: begin
          if (pop) state <= S_ISSUE;
        end
        S_ISSUE: begin
          port1_a   <= entry_addr[23:1];
          port1_ds  <= {entry_addr[0], ~entry_addr[0]};
          port1_d   <= {entry_data, entry_data};
          port1_req <= ~port1_req;
          p2_pend   <= entry_gfx;
          if (entry_gfx) begin
            port2_a   <= gfx_off[23:1];
            port2_ds  <= {gfx_off[0], ~gfx_off[0]};
            port2_d   <= {entry_data, entry_data};
            port2_req <= ~port2_req;
          end
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (acks_done) state <= pop ? S_ISSUE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (end_evt || ioctl_downl)
        dl_end_pend <= 1'b0;
      else if (ioctl_downl_d)
        dl_end_pend <= 1'b1;

      rom_loaded <= rom_nxt;
      hold_cnt   <= hold_nxt;
      core_reset <= ~rom_nxt | ioctl_downl | (hold_nxt != '0);
    end
  end

endmodule
